instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and instruction-memory loader, the inverse of the MIPS control decoder. It accepts a stream of symbolic instructions (mnemonic code plus register, immediate and target fields) over a valid/ready handshake. Each instruction is packed into a 32-bit MIPS word for the supported subset. The words are written sequentially into instruction memory from a base address. It sits between the test/boot host and the instruction-memory write port, ahead of the single-cycle datapath.

## Interface
- ADDR_W, 6, word-address width of instruction memory (capacity 2^ADDR_W words)
- BASE_ADDR, 0, first word address written after `start`
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load session; ignored unless IDLE
- in_valid  in  1  symbolic instruction present
- in_ready  out  1  encoder can accept an instruction this cycle
- in_mnem  in  4  mnemonic code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 LW, 7 SW, 8 BEQ, 9 ADDI, 10 ANDI, 11 ORI, 12 J, 13 JAL, 14–15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target field
- in_last  in  1  this instruction ends the session
- im_we  out  1  instruction-memory write strobe
- im_addr  out  ADDR_W  write word address
- im_wdata  out  32  encoded instruction word
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- full  out  1  memory filled; sticky until `start`
- err  out  1  illegal mnemonic seen; sticky until `start`
- count  out  ADDR_W+1  words written this session

## Operation
- Encoding:
  - R-type: {6'h00, rs, rt, rd, 5'd0, funct}. funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, JR 0x08.
  - JR forces rt = rd = 0.
  - I-type: {op, rs, rt, imm}. op: LW 0x23, SW 0x2B, BEQ 0x04, ADDI 0x08, ANDI 0x0C, ORI 0x0D.
  - J-type: {op, target}. op: J 0x02, JAL 0x03.
  - Unused fields of the input are ignored.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: in_ready=0, busy=0. On `start`: load im_addr=BASE_ADDR, clear count/full/err, go to ACCEPT.
  - ACCEPT: in_ready=1 unless full. On in_valid&&in_ready, register the encoded word and in_last, then go to WRITE.
  - WRITE: im_we=1 for exactly one cycle with registered addr/data. Next cycle: im_addr+1 (wraps mod 2^ADDR_W), count+1. If the registered last was set or count reaches 2^ADDR_W, go to DONE; otherwise go to ACCEPT.
  - DONE: done=1 for one cycle, then IDLE.
- full sets when count reaches 2^ADDR_W. No further words are accepted in that session. The address wrap never overwrites within one session.
- `start` while busy is ignored. in_valid outside ACCEPT is ignored; the data is not consumed.

## Timing
- Reset values: in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, busy=0, done=0, full=0, err=0, count=0, state IDLE.
- Reset asserted mid-session aborts it immediately. im_we drops asynchronously and no partial write completes.
- Handshake-to-write latency is 1 cycle: accept at cycle N, im_we at N+1.
- Throughput is one instruction per 2 cycles.
- im_wdata and im_addr are registered and stable for the whole im_we cycle.
- The last word's write occurs at cycle N+1, done at N+2, and busy falls at N+3.
- in_last together with the filling word produces a single DONE; full=1 in that case.

## Configuration
- INSTR_ENC_ILLEGAL_TRAP_EN defined:
  - An illegal mnemonic is consumed (handshake completes) but not written.
  - err sets, and address and count are unchanged.
  - If in_last was set, the session still goes to DONE.
- Undefined:
  - An illegal mnemonic is written as NOP 0x00000000 and advances address/count.
  - err still sets.

## Structure
- Shared package `instr_enc_pkg` holds:
  - mnemonic code localparams
  - opcode and funct constants (shared with the control-decoder tests)
  - FSM state typedef
- Sub-module `instr_enc_word`: purely combinational field packer (mnemonic+fields → 32-bit word, illegal flag).
- The top-level module holds the FSM, address/count registers and flags.

## Test plan
- start; ADD rs=1 rt=2 rd=3 with last → single write im_addr=0, im_wdata=0x00221820; done pulse; count=1.
- Stream LW rs=9 rt=8 imm=4; BEQ rs=1 rt=2 imm=0xFFFF; JAL target=0x10 (last) → writes 0x8D280004@0, 0x1022FFFF@1, 0x0C000010@2.
- JR rs=31 with nonzero rt/rd inputs → 0x03E00008. ORI rs=0 rt=5 imm=0x00FF → 0x340500FF.
- ADDR_W=2, BASE_ADDR=2, five instructions without last → writes at 2,3,0,1; full=1, done, count=4; fifth never accepted.
- Mnemonic 14 mid-stream → err=1. With the macro defined, no write and the address is held. Without it, 0x00000000 is written.
- Assert rst the cycle im_we is high → im_we=0 immediately; all outputs at reset values; a new start writes from BASE_ADDR.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: mnemonic codes, MIPS opcode/funct constants and encoder FSM states
package instr_enc_pkg;
    localparam logic [3:0] MN_ADD  = 4'd0;
    localparam logic [3:0] MN_SUB  = 4'd1;
    localparam logic [3:0] MN_AND  = 4'd2;
    localparam logic [3:0] MN_OR   = 4'd3;
    localparam logic [3:0] MN_SLT  = 4'd4;
    localparam logic [3:0] MN_JR   = 4'd5;
    localparam logic [3:0] MN_LW   = 4'd6;
    localparam logic [3:0] MN_SW   = 4'd7;
    localparam logic [3:0] MN_BEQ  = 4'd8;
    localparam logic [3:0] MN_ADDI = 4'd9;
    localparam logic [3:0] MN_ANDI = 4'd10;
    localparam logic [3:0] MN_ORI  = 4'd11;
    localparam logic [3:0] MN_J    = 4'd12;
    localparam logic [3:0] MN_JAL  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ACCEPT = 2'd1;
    localparam state_t S_WRITE  = 2'd2;
    localparam state_t S_DONE   = 2'd3;
endpackage

// File: rtl/instr_enc_word.sv
// instr_enc_word: packs a symbolic instruction into a 32-bit MIPS word and flags illegal mnemonics
module instr_enc_word
    import instr_enc_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);
    // Field packing per format; illegal codes yield an all-zero word (NOP)
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            MN_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            MN_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            MN_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            MN_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            MN_JR:   word = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
            MN_LW:   word = {OP_LW, rs, rt, imm};
            MN_SW:   word = {OP_SW, rs, rt, imm};
            MN_BEQ:  word = {OP_BEQ, rs, rt, imm};
            MN_ADDI: word = {OP_ADDI, rs, rt, imm};
            MN_ANDI: word = {OP_ANDI, rs, rt, imm};
            MN_ORI:  word = {OP_ORI, rs, rt, imm};
            MN_J:    word = {OP_J, target};
            MN_JAL:  word = {OP_JAL, target};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams symbolic instructions into instruction memory; INSTR_ENC_ILLEGAL_TRAP_EN drops illegal words instead of writing NOPs
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int                ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d, count_inc;
    logic [31:0]       wdata_q, wdata_d, word;
    logic              last_q, last_d, full_q, full_d, err_q, err_d;
    logic              illegal, accept;

    instr_enc_word u_word (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (word),
        .illegal (illegal)
    );

    assign in_ready  = (state_q == S_ACCEPT) && !full_q;
    assign accept    = in_valid && in_ready;
    assign im_we     = state_q == S_WRITE;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign im_addr   = addr_q;
    assign im_wdata  = wdata_q;
    assign count     = count_q;
    assign full      = full_q;
    assign err       = err_q;
    assign count_inc = count_q + 1'b1;

    // Session FSM: accept one instruction, write it the next cycle, then advance address/count
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        full_d  = full_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ACCEPT;
                addr_d  = BASE_ADDR;
                count_d = '0;
                full_d  = 1'b0;
                err_d   = 1'b0;
            end
            S_ACCEPT: if (accept) begin
                err_d = err_q | illegal;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
                if (illegal) begin
                    state_d = in_last ? S_DONE : S_ACCEPT;
                end else begin
                    wdata_d = word;
                    last_d  = in_last;
                    state_d = S_WRITE;
                end
`else
                wdata_d = word;
                last_d  = in_last;
                state_d = S_WRITE;
`endif
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_inc;
                full_d  = full_q | (count_inc == CAP);
                state_d = (last_q || count_inc == CAP) ? S_DONE : S_ACCEPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any session at once, so im_we drops asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a behavioural model
module tb_instr_encoder;
    localparam int AW   = 2;
    localparam int BASE = 2;
    localparam int CAP  = 1 << AW;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_last;
    logic [3:0]    in_mnem;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          in_ready, im_we, busy, done, full, err;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   count;

    int errors = 0;
    int checks = 0;
    int m_addr, m_cnt;
    bit m_err;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(AW'(BASE))) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .busy(busy), .done(done), .full(full), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding from the instruction-format tables using plain arithmetic
    function automatic logic [31:0] ref_word(int mn, int rs, int rt, int rd, int imm, int tgt);
        longint fn[6] = '{32, 34, 36, 37, 42, 8};
        longint op[6] = '{35, 43, 4, 8, 12, 13};
        longint w = 0;
        if (mn <= 4) w = rs * 2**21 + rt * 2**16 + rd * 2**11 + fn[mn];
        else if (mn == 5) w = rs * 2**21 + 8;
        else if (mn <= 11) w = op[mn-6] * 2**26 + rs * 2**21 + rt * 2**16 + imm;
        else if (mn <= 13) w = longint'(mn - 10) * 2**26 + tgt;
        return w[31:0];
    endfunction

    task automatic open_session();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_addr = BASE;
        m_cnt  = 0;
        m_err  = 1'b0;
        check("start_busy", busy, 1);
        check("start_addr", im_addr, BASE);
        check("start_count", count, 0);
        check("start_full", full, 0);
    endtask

    // Issues one instruction and checks write, latency and end-of-session behaviour
    task automatic issue(int mn, int rs, int rt, int rd, int imm, int tgt, bit last);
        logic [31:0] exp;
        bit ill, wr, fin;
        int n = 0;
        in_mnem = 4'(mn); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("ready_wait", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        ill = mn > 13;
        wr  = !ill || !TRAP;
        exp = ill ? 32'h0 : ref_word(mn, rs, rt, rd, imm, tgt);
        if (ill) m_err = 1'b1;
        check("we", im_we, wr);
        if (wr) begin
            check("addr", im_addr, m_addr);
            check("data", im_wdata, exp);
            m_addr = (m_addr + 1) % CAP;
            m_cnt++;
            @(posedge clk); #1;
            check("we_one", im_we, 0);
        end
        fin = last || m_cnt == CAP;
        check("count", count, m_cnt);
        check("done", done, fin);
        if (fin) begin
            check("full", full, m_cnt == CAP);
            check("err", err, m_err);
            @(posedge clk); #1;
            check("busy_end", busy, 0);
            check("done_once", done, 0);
        end else begin
            check("ready_again", in_ready, 1);
        end
    endtask

    task automatic rand_issue(int mn, bit last);
        issue(mn, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1), last);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", im_we, 0);
        check("rst_ready", in_ready, 0);
        check("rst_addr", im_addr, BASE);
        check("rst_wdata", im_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("idle_ready", in_ready, 0);
            check("idle_we", im_we, 0);
        end
        in_valid = 1'b0;

        open_session();
        issue(0, 1, 2, 3, 0, 0, 1'b1);

        open_session();
        issue(6, 9, 8, 0, 4, 0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_ignored_addr", im_addr, m_addr);
        issue(8, 1, 2, 0, 16'hFFFF, 0, 1'b0);
        issue(13, 0, 0, 0, 0, 26'h10, 1'b1);

        open_session();
        issue(5, 31, 7, 9, 0, 0, 1'b0);
        issue(11, 0, 5, 0, 16'h00FF, 0, 1'b1);

        open_session();
        for (int i = 0; i < 4; i++) rand_issue($urandom_range(0, 13), 1'b0);
        in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("fifth_we", im_we, 0);
            check("fifth_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        open_session();
        for (int i = 0; i < 3; i++) rand_issue($urandom_range(0, 13), 1'b0);
        rand_issue($urandom_range(0, 13), 1'b1);

        open_session();
        rand_issue(0, 1'b0);
        rand_issue(14, 1'b0);
        rand_issue(1, 1'b1);

        open_session();
        rand_issue(15, 1'b1);

        for (int s = 0; s < 15; s++) begin
            int len;
            len = $urandom_range(1, 6);
            open_session();
            for (int i = 0; i < len && m_cnt < CAP; i++) begin
                int mn;
                mn = ($urandom_range(0, 99) < 15) ? $urandom_range(14, 15) : $urandom_range(0, 13);
                rand_issue(mn, i == len - 1);
            end
        end

        open_session();
        in_mnem = 4'd0; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        check("abort_we_pre", im_we, 1);
        rst = 1'b1;
        #1;
        check("abort_we", im_we, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 0);
        check("abort_addr", im_addr, BASE);
        check("abort_wdata", im_wdata, 0);
        check("abort_count", count, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_we", im_we, 0);
        open_session();
        issue(2, 7, 8, 9, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
